// File: rtl/game_state_engine.sv
// game_state_engine: run/over state machine for a side-scrolling runner game.
// It handles the BCD score and high score, the scroll speed ramp, the obstacle
// channels with their spawn spacing, and a free-running LFSR that jitters the
// gap between spawns.
module game_state_engine #(
    parameter int unsigned NUM_OBS    = 2,
    parameter int unsigned DIGITS     = 5,
    parameter int unsigned X_W        = 10,
    parameter int unsigned RESPAWN_X  = 640,
    parameter int unsigned SCORE_DIV  = 16,
    parameter int unsigned BASE_SPEED = 2,
    parameter int unsigned MAX_SPEED  = 15,
    parameter int unsigned MIN_GAP    = 200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic                   collide,
    output logic [NUM_OBS*X_W-1:0] obs_x,
    output logic [NUM_OBS-1:0]     obs_active,
    output logic [1:0]             state,
    output logic                   game_over,
    output logic [4*DIGITS-1:0]    score_bcd,
    output logic [4*DIGITS-1:0]    high_bcd,
    output logic [3:0]             speed
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [X_W-1:0]         LP_RESPAWN = X_W'(RESPAWN_X);
    localparam logic [NUM_OBS*X_W-1:0] LP_X_ALL   = {NUM_OBS{LP_RESPAWN}};
    localparam logic [3:0]             LP_BASE    = 4'(BASE_SPEED);
    localparam logic [3:0]             LP_MAX     = 4'(MAX_SPEED);

    state_t                   r_state;
    logic                     r_game_over;
    logic [4*DIGITS-1:0]      r_score;
    logic [4*DIGITS-1:0]      r_high;
    logic [3:0]               r_speed;
    logic [15:0]              r_div;
    logic [15:0]              r_cnt;
    logic [NUM_OBS-1:0]       r_act;
    logic [NUM_OBS*X_W-1:0]   r_obs_x;
    logic [15:0]              r_lfsr;

    logic [4*DIGITS-1:0]      w_score_inc;
    logic                     w_carry;
    logic                     w_all9;
    logic                     w_low_roll;
    logic [15:0]              w_div_inc;
    logic                     w_div_wrap;
    logic [15:0]              w_div_next;
    logic [4*DIGITS-1:0]      w_score_next;
    logic [3:0]               w_speed_next;
    logic [NUM_OBS-1:0]       w_act_next;
    logic [NUM_OBS*X_W-1:0]   w_x_next;
    logic [15:0]              w_cnt_dec;
    logic [15:0]              w_cnt_next;
    logic                     w_found;
    logic [X_W-1:0]           w_spd_x;
    logic [15:0]              w_spd_16;

    assign state      = r_state;
    assign game_over  = r_game_over;
    assign score_bcd  = r_score;
    assign high_bcd   = r_high;
    assign speed      = r_speed;
    assign obs_active = r_act;
    assign obs_x      = r_obs_x;

    assign w_spd_x  = X_W'(r_speed);
    assign w_spd_16 = 16'(r_speed);

    // Score: BCD increment with per-digit carry, saturation detect, and 99->00 roll of the low two digits
    always_comb begin
        w_score_inc = r_score;
        w_carry     = 1'b1;
        w_all9      = 1'b1;
        w_low_roll  = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_score[d*4 +: 4] != 4'd9) w_all9 = 1'b0;
            if (w_carry) begin
                if (r_score[d*4 +: 4] == 4'd9) begin
                    w_score_inc[d*4 +: 4] = 4'd0;
                end else begin
                    w_score_inc[d*4 +: 4] = r_score[d*4 +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
        for (int unsigned d = 0; d < 2; d++) begin
            if (d >= DIGITS) w_low_roll = 1'b0;
            else if (r_score[d*4 +: 4] != 4'd9) w_low_roll = 1'b0;
        end
        w_div_inc    = r_div + 16'd1;
        w_div_wrap   = (w_div_inc == 16'(SCORE_DIV));
        w_div_next   = w_div_wrap ? 16'd0 : w_div_inc;
        w_score_next = (w_div_wrap && !w_all9) ? w_score_inc : r_score;
        w_speed_next = (w_div_wrap && !w_all9 && w_low_roll && (r_speed < LP_MAX))
                       ? r_speed + 4'd1 : r_speed;
    end

    // Obstacles: move or retire active channels, then spawn into the lowest channel that was already free
    always_comb begin
        w_act_next = r_act;
        w_x_next   = r_obs_x;
        w_found    = 1'b0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            if (r_act[i]) begin
                if (r_obs_x[i*X_W +: X_W] < w_spd_x) begin
                    w_act_next[i]          = 1'b0;
                    w_x_next[i*X_W +: X_W] = LP_RESPAWN;
                end else begin
                    w_x_next[i*X_W +: X_W] = r_obs_x[i*X_W +: X_W] - w_spd_x;
                end
            end
        end
        w_cnt_dec  = (r_cnt > w_spd_16) ? r_cnt - w_spd_16 : 16'd0;
        w_cnt_next = w_cnt_dec;
        if (w_cnt_dec == 16'd0) begin
            // eligibility uses r_act, so a channel retiring this frame cannot respawn in the same frame
            for (int unsigned i = 0; i < NUM_OBS; i++) begin
                if (!r_act[i] && !w_found) begin
                    w_found                = 1'b1;
                    w_act_next[i]          = 1'b1;
                    w_x_next[i*X_W +: X_W] = LP_RESPAWN;
                end
            end
            if (w_found) w_cnt_next = 16'(MIN_GAP) + 16'(r_lfsr[6:0]);
        end
    end

    // Game FSM with registered outputs; collide takes priority over frame_tick in RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b0;
            r_score     <= '0;
            r_high      <= '0;
            r_speed     <= LP_BASE;
            r_div       <= '0;
            r_cnt       <= '0;
            r_act       <= '0;
            r_obs_x     <= LP_X_ALL;
        end else begin
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_game_over <= 1'b0;
                        r_score     <= '0;
                        r_speed     <= LP_BASE;
                        r_div       <= '0;
                        r_cnt       <= '0;
                        r_act       <= '0;
                        r_obs_x     <= LP_X_ALL;
                    end
                end
                ST_RUN: begin
                    if (collide) begin
                        r_state     <= ST_OVER;
                        r_game_over <= 1'b1;
                        if (r_score > r_high) r_high <= r_score;
                    end else if (frame_tick) begin
                        r_score <= w_score_next;
                        r_speed <= w_speed_next;
                        r_div   <= w_div_next;
                        r_cnt   <= w_cnt_next;
                        r_act   <= w_act_next;
                        r_obs_x <= w_x_next;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    // Spawn-gap LFSR: Fibonacci taps 16,14,13,11, free-running in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

endmodule

// File: tb/tb_game_state_engine.sv
// Scoreboard bench for game_state_engine: the stimulus process updates a
// behavioural model and queues the expected outputs; the monitor compares
// them against the DUT one time unit after each rising edge.
module tb_game_state_engine;

    localparam int NOBS = 2;
    localparam int DIG  = 3;
    localparam int XW   = 10;
    localparam int RX   = 640;
    localparam int SDIV = 2;
    localparam int BSPD = 2;
    localparam int MSPD = 6;
    localparam int GAP  = 200;

    logic                clk = 1'b0;
    logic                reset, frame_tick, start, collide;
    logic [NOBS*XW-1:0]  obs_x;
    logic [NOBS-1:0]     obs_active;
    logic [1:0]          state;
    logic                game_over;
    logic [4*DIG-1:0]    score_bcd, high_bcd;
    logic [3:0]          speed;

    game_state_engine #(
        .NUM_OBS(NOBS), .DIGITS(DIG), .X_W(XW), .RESPAWN_X(RX),
        .SCORE_DIV(SDIV), .BASE_SPEED(BSPD), .MAX_SPEED(MSPD), .MIN_GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .collide(collide), .obs_x(obs_x), .obs_active(obs_active),
        .state(state), .game_over(game_over), .score_bcd(score_bcd),
        .high_bcd(high_bcd), .speed(speed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         st;
        logic               go;
        logic [NOBS*XW-1:0] x;
        logic [NOBS-1:0]    act;
        logic [4*DIG-1:0]   sc;
        logic [4*DIG-1:0]   hi;
        logic [3:0]         spd;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // behavioural model: plain integers, state as 0 idle / 1 run / 2 over
    int          m_st, m_score, m_high, m_speed, m_div, m_cnt;
    int          m_x[NOBS];
    bit          m_act[NOBS];
    logic [15:0] m_lfsr;
    int          smax;

    function automatic logic [4*DIG-1:0] to_bcd(input int v);
        logic [4*DIG-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIG; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.st  = 2'(m_st);
        e.go  = (m_st == 2);
        for (int i = 0; i < NOBS; i++) begin
            e.x[i*XW +: XW] = XW'(m_x[i]);
            e.act[i]        = m_act[i];
        end
        e.sc  = to_bcd(m_score);
        e.hi  = to_bcd(m_high);
        e.spd = 4'(m_speed);
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0; m_score = 0; m_high = 0; m_speed = BSPD; m_div = 0; m_cnt = 0;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < NOBS; i++) begin m_x[i] = RX; m_act[i] = 0; end
    endtask

    task automatic model_frame(input logic [15:0] lf);
        int sp;
        bit was_free[NOBS];
        sp = m_speed;
        m_div++;
        if (m_div == SDIV) begin
            m_div = 0;
            if (m_score < smax) begin
                if (m_score % 100 == 99 && m_speed < MSPD) m_speed++;
                m_score++;
            end
        end
        for (int i = 0; i < NOBS; i++) begin
            was_free[i] = !m_act[i];
            if (m_act[i]) begin
                if (m_x[i] < sp) begin m_act[i] = 0; m_x[i] = RX; end
                else m_x[i] = m_x[i] - sp;
            end
        end
        m_cnt = (m_cnt > sp) ? m_cnt - sp : 0;
        if (m_cnt == 0) begin
            for (int i = 0; i < NOBS; i++) begin
                if (was_free[i]) begin
                    m_act[i] = 1; m_x[i] = RX;
                    m_cnt = GAP + int'(lf[6:0]);
                    break;
                end
            end
        end
    endtask

    // one clock of stimulus: drive inputs at the falling edge, predict the next rising edge
    task automatic step(input bit s, input bit c, input bit f);
        logic [15:0] lf;
        start = s; collide = c; frame_tick = f;
        lf = m_lfsr;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (m_st != 1) begin
            if (s) begin
                m_st = 1; m_score = 0; m_speed = BSPD; m_div = 0; m_cnt = 0;
                for (int i = 0; i < NOBS; i++) begin m_x[i] = RX; m_act[i] = 0; end
            end
        end else if (c) begin
            m_st = 2;
            if (m_score > m_high) m_high = m_score;
        end else if (f) begin
            model_frame(lf);
        end
        q.push_back(snap());
        @(negedge clk);
    endtask

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp, inout bit bad);
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
            bad = 1;
        end
    endtask

    // asynchronous reset must take effect without waiting for a clock edge
    task automatic chk_reset_now();
        bit bad;
        bad = 0;
        n_vec++;
        cmp("rst_state", 32'(state), 32'd0, bad);
        cmp("rst_game_over", 32'(game_over), 32'd0, bad);
        cmp("rst_active", 32'(obs_active), 32'd0, bad);
        for (int i = 0; i < NOBS; i++) cmp("rst_obs_x", 32'(obs_x[i*XW +: XW]), 32'(RX), bad);
        cmp("rst_score", 32'(score_bcd), 32'd0, bad);
        cmp("rst_high", 32'(high_bcd), 32'd0, bad);
        cmp("rst_speed", 32'(speed), 32'(BSPD), bad);
        if (bad) n_miss++;
    endtask

    task automatic pulse_reset();
        start = 0; collide = 0; frame_tick = 0;
        reset = 1'b0;
        #1;
        chk_reset_now();
        model_reset();
        q.push_back(snap());
        @(negedge clk);
        reset = 1'b1;
    endtask

    // monitor: pop one expectation per rising edge and compare
    initial begin
        exp_t e;
        bit bad;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                bad = 0;
                n_vec++;
                cmp("state", 32'(state), 32'(e.st), bad);
                cmp("game_over", 32'(game_over), 32'(e.go), bad);
                cmp("obs_x", 32'(obs_x), 32'(e.x), bad);
                cmp("obs_active", 32'(obs_active), 32'(e.act), bad);
                cmp("score_bcd", 32'(score_bcd), 32'(e.sc), bad);
                cmp("high_bcd", 32'(high_bcd), 32'(e.hi), bad);
                cmp("speed", 32'(speed), 32'(e.spd), bad);
                if (bad) n_miss++;
            end
        end
    end

    initial begin
        smax = 1;
        for (int d = 0; d < DIG; d++) smax = smax * 10;
        smax = smax - 1;
        reset = 1'b0; start = 0; collide = 0; frame_tick = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_now();
        reset = 1'b1;

        // start, first spawn at RESPAWN_X, then first move by BASE_SPEED
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // long collision-free run: speed ramp, spawn/retire traffic, score saturation
        for (int i = 0; i < 2100; i++) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 1, 0);

        // fresh session: collide with a tick at 42, then lose at 30 with high kept
        pulse_reset();
        step(1, 0, 0);
        for (int i = 0; i < 84; i++) step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        for (int i = 0; i < 60; i++) step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);

        // reset in the middle of a run discards everything, including high score
        step(1, 0, 0);
        for (int i = 0; i < 1000; i++) step(0, 0, 1);
        pulse_reset();
        step(0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 1499) == 0) pulse_reset();
            else step($urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0,
                      $urandom_range(0, 1) == 1);
        end

        start = 0; collide = 0; frame_tick = 0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/game_state_engine.md
GAME_STATE_ENGINE -- requirements
Module: game_state_engine

Interface
REQ-001 Parameter NUM_OBS, default 2, number of independent obstacle channels (1..8).
REQ-002 Parameter DIGITS, default 5, number of BCD score digits (1..8).
REQ-003 Parameter X_W, default 10, obstacle x-coordinate width in bits.
REQ-004 Parameter RESPAWN_X, default 640, x value loaded on spawn or retire.
REQ-005 Parameter SCORE_DIV, default 16, frame ticks per score increment.
REQ-006 Parameter BASE_SPEED, default 2, pixels per frame at run start.
REQ-007 Parameter MAX_SPEED, default 15, speed saturation value (<=15).
REQ-008 Parameter MIN_GAP, default 200, minimum spawn spacing in pixels.
REQ-009 clk  in  1  system clock; single clock domain.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 frame_tick  in  1  one-cycle pulse per video frame (screenEnd-derived).
REQ-012 start  in  1  level; start a run from IDLE or OVER.
REQ-013 collide  in  1  per-cycle sprite-overlap flag from the pixel path.
REQ-014 obs_x  out  NUM_OBS*X_W  packed obstacle x positions, channel 0 in LSBs.
REQ-015 obs_active  out  NUM_OBS  per-channel visible flag.
REQ-016 state  out  2  00 IDLE, 01 RUN, 10 OVER.
REQ-017 game_over  out  1  high while state is OVER.
REQ-018 score_bcd  out  4*DIGITS  current score, digit 0 (units) in LSBs.
REQ-019 high_bcd  out  4*DIGITS  best score since reset, same packing.
REQ-020 speed  out  4  current scroll speed, pixels per frame.

Function
REQ-021 FSM: IDLE->RUN when start=1; RUN->OVER on any cycle with collide=1; OVER->RUN when start=1; start in RUN ignored; collide outside RUN ignored.
REQ-022 Entering RUN (from IDLE or OVER) SHALL, in the same edge: clear score_bcd, frame divider and spawn counter; set speed=BASE_SPEED; deactivate all channels; set all obs_x=RESPAWN_X.
REQ-023 Only frame_tick cycles in RUN SHALL update score, speed, positions and spawn; all are frozen in IDLE and OVER.
REQ-024 Frame divider SHALL count frame_tick in RUN; on reaching SCORE_DIV it wraps to 0 and score_bcd increments by 1 with decimal carry per digit.
REQ-025 score_bcd SHALL saturate at all digits 9; no wrap.
REQ-026 Each time score digits 1:0 roll from 99 to 00, speed SHALL increment by 1, saturating at MAX_SPEED.
REQ-027 Per frame_tick, each active channel SHALL do x <= x - speed; if x < speed the channel retires instead: obs_active=0, x=RESPAWN_X.
REQ-028 Spawn counter (unsigned, 16 bits) SHALL decrement by speed per frame_tick, floored at 0.
REQ-029 When spawn counter is 0 after the decrement and any channel is inactive, the lowest-index inactive channel SHALL activate at x=RESPAWN_X and the counter reloads MIN_GAP + lfsr[6:0].
REQ-030 Spawned channel SHALL not move on its spawn frame; channel retiring this frame is not eligible to spawn this frame.
REQ-031 No free channel: counter holds at 0; spawn occurs on the first frame a channel is free.
REQ-032 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances every clk in all states, never reaches zero.
REQ-033 collide and frame_tick in the same RUN cycle: move to OVER, no position/score/speed update that cycle.
REQ-034 On RUN->OVER, high_bcd SHALL load score_bcd if score_bcd > high_bcd (unsigned digit-wise compare), else hold; latency one clk.
REQ-035 Outputs SHALL be registered; all updates visible the cycle after the triggering edge.

Reset
REQ-036 reset=0 SHALL asynchronously force: state IDLE, game_over 0, obs_active 0, all obs_x=RESPAWN_X, score_bcd 0, high_bcd 0, speed BASE_SPEED, divider 0, spawn counter 0, LFSR 16'hACE1.
REQ-037 Reset asserted mid-run SHALL discard the run including high_bcd; release resumes in IDLE.

Verification
REQ-038 Reset release, start=1 one cycle, one frame_tick -> state 01, obs_active=01, obs_x[0]=640; next frame_tick -> obs_x[0]=638.
REQ-039 RUN, 16*100 frame_ticks no collide -> score_bcd=00100, speed=3; 16*99999+extra ticks -> score stays 99999, speed=15.
REQ-040 Channel 0 at x=1, speed 2, frame_tick -> obs_active[0]=0, obs_x[0]=640; both channels busy with spawn counter 0 -> spawn deferred until a retire frame+1.
REQ-041 Score 00042, collide=1 coincident with frame_tick -> state 10, game_over 1, score 00042, high_bcd 00042; restart, collide at score 00030 -> high_bcd stays 00042.
REQ-042 Reset pulsed low in RUN at score 00500 -> all outputs at REQ-036 values immediately, high_bcd 00000.
